// File: rtl/division_control.sv
// Sequential unsigned restoring divider: one (M+1)-bit ripple subtractor reused over M iterations.
// Optional macro DIVISION_ZERO_CHECK_EN enables the zero-divisor shortcut and the div_zero flag.
module division_control #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = (M > 2) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [M-1:0]    p;
  logic [M-1:0]    q;
  logic [M-1:0]    d;
  logic [CW-1:0]   cnt;

  logic [M:0]      s;
  logic [M:0]      sub;
  logic [M-1:0]    p_nxt;
  logic [M-1:0]    q_nxt;

  // Ripple subtract a - {0,b}: b inverted with carry-in 1. Returns {carry_out, diff[M-1:0]}.
  // The top difference bit is never needed because a kept difference is always below the divisor.
  function automatic logic [M:0] ripple_sub(input logic [M:0] a, input logic [M-1:0] b);
    logic         c;
    logic [M-1:0] diff;
    c = 1'b1;
    for (int i = 0; i < M; i++) begin
      diff[i] = a[i] ^ ~b[i] ^ c;
      c       = (a[i] & ~b[i]) | (a[i] & c) | (~b[i] & c);
    end
    c = a[M] | c;
    return {c, diff};
  endfunction

  // The stored partial remainder never reaches 2^M, so its top bit is implicit zero.
  always_comb begin
    s     = {p, q[M-1]};
    sub   = ripple_sub(s, d);
    p_nxt = sub[M] ? sub[M-1:0] : s[M-1:0];
    q_nxt = {q[M-2:0], sub[M]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q    <= dividend;
            d    <= divisor;
            p    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef DIVISION_ZERO_CHECK_EN
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          p   <= p_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(M - 1)) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_nxt;
            remainder <= p_nxt;
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
